branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer and controller that sequences the 2-bit branch-history state for each entry.
- Fetch stage issues a PC lookup and gets a taken/not-taken prediction plus target in the same cycle.
- MEM stage writes back the resolved outcome.
- Owns table initialisation after reset or an explicit clear, and rules for lookup/update collisions.

Parameters:
ENTRIES, 16, number of table entries (power of two, 4..64).
IDX_W, $clog2(ENTRIES), index width (derived; not overridden).

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
fetch_pc  input  32  PC being fetched (word aligned)
predict_valid  output  1  tag hit on a valid entry
predict_taken  output  1  predicted direction (state bit 1 of hit entry)
predict_target  output  32  stored target of hit entry
upd_en  input  1  MEM stage resolved a branch this cycle
upd_pc  input  32  PC of resolved branch
upd_taken  input  1  actual outcome
upd_target  input  32  actual target
clear  input  1  flush whole table (single-cycle pulse or level)
ready  output  1  table initialised; updates accepted

Behaviour:
- Clock and reset: one clock `CLK`; `nRST` is asynchronous and active-low.
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:0], state[1:0].
- State encoding:
  - 11 hard taken
  - 10 soft taken
  - 00 hard not taken
  - 01 soft not taken
- Controller FSM states: INIT and READY.
- Reset (async, nRST low):
  - FSM = INIT, clear index = 0, ready = 0.
  - Table contents unspecified until overwritten by INIT.
- INIT:
  - Each cycle writes entry[clear index] with valid = 0 and state = 00, then increments the clear index.
  - On the edge that clears index ENTRIES-1, FSM goes to READY and ready goes to 1.
  - ready rises exactly ENTRIES edges after nRST deasserts.
  - upd_en is ignored in INIT.
  - predict_valid/predict_taken = 0 and predict_target = 0 in INIT.
- READY lookup:
  - Combinational, zero latency.
  - predict_valid = entry.valid and tag match.
  - predict_taken = predict_valid and state[1].
  - predict_target = entry.target if hit, else 0.
- READY update (applied at posedge when upd_en = 1):
  - Hit, taken: 00→01, 01→11, 10→11, 11→11; target overwritten with upd_target.
  - Hit, not taken: 11→10, 10→00, 01→00, 00→00; target unchanged.
  - Miss, taken: allocate (replace) with valid = 1, tag, target = upd_target, state = 10.
  - Miss, not taken: no write.
- clear:
  - In READY: next edge FSM = INIT, clear index = 0, ready = 0; any upd_en that cycle is dropped.
  - In INIT: clear index restarts at 0.
  - clear has priority over upd_en.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents unless the bypass feature is enabled.
- Reset mid-INIT or mid-update: asynchronous return to reset state; partial writes are discarded.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when upd_en is accepted in READY and upd_pc index equals fetch_pc index, predict_* reflect the post-update entry in the same cycle. This holds for both hit and allocate; a not-taken miss is not bypassed.
- Undefined: the lookup sees old contents, as stated above.

Decomposition:
- cpu_types_pkg: word_t (32 bits).
- New typedefs in cpu_types_pkg:
  - bp_state_t enum (HARD_TAKEN = 2'b11, SOFT_TAKEN = 2'b10, HARD_NOT_TAKEN = 2'b00, SOFT_NOT_TAKEN = 2'b01)
  - btb_entry_t struct packed (valid, tag, target, state)
  - btb_fsm_t enum (INIT, READY)
- Interface file: branch_target_buffer_if.vh, bundling all non-clock/reset ports.
- Sub-module: bp_counter_next, a combinational next-state function of (state, taken), instantiated once in the update path.

Test Plan:
- nRST low then high, ENTRIES = 16 → ready = 0 for 16 edges, ready = 1 after the 16th; predict_valid = 0 for fetch_pc = 0x0000_0040 throughout.
- In READY, upd_en with upd_pc = 0x0000_0044, upd_taken = 1, upd_target = 0x0000_0100; next cycle fetch_pc = 0x0000_0044 → predict_valid = 1, predict_taken = 1, predict_target = 0x0000_0100 (state 10).
- Same PC, three further not-taken updates → states 00, 00, 00; predict_taken = 0, predict_valid = 1. Then two taken updates → 01, then 11; predict_taken = 1.
- Aliasing: entry for 0x0000_0044 valid; taken update at 0x0000_0084 (same index 1, different tag) → 0x44 now misses, 0x84 hits at state 10. A not-taken update at 0x0000_00C4 writes nothing.
- clear pulsed while upd_en = 1 → update dropped, ready low for 16 edges, all lookups miss afterwards. clear reasserted at clear index 7 → ready delayed to 16 edges after the second pulse.
- Same cycle upd_en (0x44, taken) and fetch_pc = 0x44 on an empty entry:
  - Without BTB_BYPASS_EN: predict_valid = 0.
  - With BTB_BYPASS_EN: predict_valid = 1, target = upd_target.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_pkg
//
// Shared types for the branch target buffer slice.
//   word_t        : 32-bit machine word (PCs and targets)
//   bp_state_t    : 2-bit branch-history state of one entry
//   btb_entry_t   : one table entry {valid, tag, target, state}
//   btb_fsm_t     : controller state (INIT while the table is being wiped)
//   pc_tag()      : extracts the tag field of a PC for a given index width
//
// The tag field is sized for the smallest legal table (4 entries, 2 index
// bits), so one packed entry type serves every ENTRIES value; for larger
// tables the upper tag bits are simply zero-extended.
//
// Optional feature macro used by the slice: BTB_BYPASS_EN (see top file).
// ---------------------------------------------------------------------------
package branch_target_buffer_pkg;

    typedef logic [31:0] word_t;

    // 32-bit PC minus 2 byte-offset bits minus at least 2 index bits.
    localparam int BTB_TAG_W = 28;

    typedef logic [BTB_TAG_W-1:0] btb_tag_t;

    // Bit 1 is the predicted direction; bit 0 distinguishes hard/soft but
    // with a non-obvious polarity (01 is soft NOT taken, 10 is soft taken).
    typedef enum logic [1:0] {
        HARD_NOT_TAKEN = 2'b00,
        SOFT_NOT_TAKEN = 2'b01,
        SOFT_TAKEN     = 2'b10,
        HARD_TAKEN     = 2'b11
    } bp_state_t;

    typedef struct packed {
        logic      valid;
        btb_tag_t  tag;
        word_t     target;
        bp_state_t state;
    } btb_entry_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } btb_fsm_t;

    // Tag = pc[31:idx_w+2], right-justified into the fixed-width tag field.
    function automatic btb_tag_t pc_tag(input word_t pc, input int idx_w);
        word_t shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[BTB_TAG_W-1:0];
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_if
//
// Bundles every non-clock/reset signal of the branch target buffer.
//   fetch_pc       : PC presented by fetch for a same-cycle lookup
//   predict_valid  : lookup hit a valid entry with matching tag
//   predict_taken  : predicted direction of the hit entry
//   predict_target : stored target of the hit entry (0 on miss)
//   upd_en         : MEM stage resolved a branch this cycle
//   upd_pc         : PC of the resolved branch
//   upd_taken      : actual outcome
//   upd_target     : actual target
//   clear          : flush whole table (pulse or level)
//   ready          : table initialised, updates accepted
//
// Handshake: there is no back-pressure. An update is consumed on any rising
// clock edge where upd_en = 1, ready = 1 and clear = 0; with ready = 0 or
// clear = 1 the update is silently dropped. Lookups are purely combinational.
//
// Modports: master = CPU pipeline side, slave = the buffer.
// ---------------------------------------------------------------------------
interface branch_target_buffer_if;
    import branch_target_buffer_pkg::*;

    word_t fetch_pc;
    logic  predict_valid;
    logic  predict_taken;
    word_t predict_target;
    logic  upd_en;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  clear;
    logic  ready;

    modport master (
        output fetch_pc, upd_en, upd_pc, upd_taken, upd_target, clear,
        input  predict_valid, predict_taken, predict_target, ready
    );

    modport slave (
        input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target, clear,
        output predict_valid, predict_taken, predict_target, ready
    );

endinterface

// File: rtl/branch_target_buffer_bp_counter_next.sv
// ---------------------------------------------------------------------------
// bp_counter_next
//
// Combinational next-state function for a 2-bit branch-history state.
//   state_i : current state of the hit entry
//   taken_i : resolved branch outcome
//   state_o : state to write back
//
// Taken:     00->01, 01->11, 10->11, 11->11
// Not taken: 11->10, 10->00, 01->00, 00->00
// A soft-not-taken entry that sees another taken branch jumps straight to
// hard taken, and a soft-taken entry that sees not-taken falls to hard
// not taken; only the hard states need two mispredictions to flip.
// ---------------------------------------------------------------------------
module bp_counter_next
    import branch_target_buffer_pkg::*;
(
    input  bp_state_t state_i,
    input  logic      taken_i,
    output bp_state_t state_o
);

    always_comb begin
        state_o = state_i;
        if (taken_i) begin
            unique case (state_i)
                HARD_NOT_TAKEN: state_o = SOFT_NOT_TAKEN;
                SOFT_NOT_TAKEN: state_o = HARD_TAKEN;
                SOFT_TAKEN:     state_o = HARD_TAKEN;
                HARD_TAKEN:     state_o = HARD_TAKEN;
                default:        state_o = HARD_NOT_TAKEN;
            endcase
        end else begin
            unique case (state_i)
                HARD_TAKEN:     state_o = SOFT_TAKEN;
                SOFT_TAKEN:     state_o = HARD_NOT_TAKEN;
                SOFT_NOT_TAKEN: state_o = HARD_NOT_TAKEN;
                HARD_NOT_TAKEN: state_o = HARD_NOT_TAKEN;
                default:        state_o = HARD_NOT_TAKEN;
            endcase
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with 2-bit branch-history per entry and
// a small controller that wipes the table after reset or clear.
//
// Ports:
//   CLK       : system clock
//   nRST      : asynchronous active-low reset
//   bus       : branch_target_buffer_if.slave (lookup, update, clear, ready)
//   dbg_state : current controller state (INIT / READY) for observation
//
// Parameters:
//   ENTRIES   : number of entries, power of two in 4..64
//   IDX_W     : derived index width
//
// Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
//
// Build option:
//   BTB_BYPASS_EN defined   -> a lookup that shares its index with an
//                              accepted update sees the post-update entry.
//   BTB_BYPASS_EN undefined -> lookups always see the pre-update contents.
// ---------------------------------------------------------------------------
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    branch_target_buffer_if.slave         bus,
    output btb_fsm_t                      dbg_state
);

    typedef logic [IDX_W-1:0] idx_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    btb_fsm_t   state_q, state_d;
    idx_t       clr_idx_q, clr_idx_d;

    // Table storage has no reset: INIT overwrites every entry before any
    // lookup is allowed to report a hit.
    btb_entry_t table_q [ENTRIES];

    // Single write port shared by the INIT wipe and READY updates.
    logic       wr_en;
    idx_t       wr_idx;
    btb_entry_t wr_entry;
    logic       upd_wr;

    // Update-side decode
    idx_t       upd_idx;
    btb_tag_t   upd_tag;
    btb_entry_t upd_old;
    logic       upd_hit;
    bp_state_t  ctr_next;

    // Lookup-side decode
    idx_t       fetch_idx;
    btb_tag_t   fetch_tag;
    btb_entry_t fetch_rd;
    logic       fetch_hit;

    // Byte-offset bits of both PCs carry no information (word aligned).
    logic       unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Update path
    // -----------------------------------------------------------------------
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = pc_tag(bus.upd_pc, IDX_W);
    assign upd_old = table_q[upd_idx];
    assign upd_hit = upd_old.valid && (upd_old.tag == upd_tag);

    bp_counter_next u_counter_next (
        .state_i (upd_old.state),
        .taken_i (bus.upd_taken),
        .state_o (ctr_next)
    );

    // -----------------------------------------------------------------------
    // Controller: next state, clear index and table write request
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_en     = 1'b0;
        upd_wr    = 1'b0;
        wr_idx    = clr_idx_q;
        wr_entry  = '0;

        unique case (state_q)
            INIT: begin
                // Wipe one entry per cycle; updates are ignored here.
                wr_en    = 1'b1;
                wr_idx   = clr_idx_q;
                wr_entry = '{valid: 1'b0, tag: '0, target: '0,
                             state: HARD_NOT_TAKEN};
                if (bus.clear) begin
                    // Restart the sweep; the full ENTRIES cycles follow.
                    clr_idx_d = '0;
                end else if (clr_idx_q == idx_t'(ENTRIES - 1)) begin
                    state_d   = READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + idx_t'(1);
                end
            end

            READY: begin
                if (bus.clear) begin
                    // clear wins over a same-cycle update, which is dropped.
                    state_d   = INIT;
                    clr_idx_d = '0;
                end else if (bus.upd_en) begin
                    wr_idx = upd_idx;
                    if (upd_hit) begin
                        upd_wr         = 1'b1;
                        wr_entry       = upd_old;
                        wr_entry.state = ctr_next;
                        if (bus.upd_taken) begin
                            wr_entry.target = bus.upd_target;
                        end
                    end else if (bus.upd_taken) begin
                        // Taken miss replaces whatever occupied the slot.
                        upd_wr   = 1'b1;
                        wr_entry = '{valid: 1'b1, tag: upd_tag,
                                     target: bus.upd_target,
                                     state: SOFT_TAKEN};
                    end
                    // Not-taken miss: nothing worth remembering.
                    wr_en = upd_wr;
                end
            end

            default: begin
                state_d   = INIT;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup path (combinational, zero latency)
    // -----------------------------------------------------------------------
    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign fetch_tag = pc_tag(bus.fetch_pc, IDX_W);

    always_comb begin
        fetch_rd = table_q[fetch_idx];
`ifdef BTB_BYPASS_EN
        // Forward the entry being written this cycle. upd_wr is only set
        // for accepted READY updates that actually write, so a not-taken
        // miss (no write) is never forwarded.
        if (upd_wr && (upd_idx == fetch_idx)) begin
            fetch_rd = wr_entry;
        end
`endif
    end

    assign fetch_hit = (state_q == READY) && fetch_rd.valid &&
                       (fetch_rd.tag == fetch_tag);

    assign bus.predict_valid  = fetch_hit;
    assign bus.predict_taken  = fetch_hit && fetch_rd.state[1];
    assign bus.predict_target = fetch_hit ? fetch_rd.target : '0;
    assign bus.ready          = (state_q == READY);
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  branch_target_buffer_if bif ();
  btb_fsm_t dbg_state;

  branch_target_buffer #(.ENTRIES(N)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bif.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  bit          m_valid [N];
  logic [25:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  logic [1:0]  m_st    [N];
  bit          m_ready;
  int          m_cnt;

  logic [31:0] cur_fpc, cur_upc, cur_utg;
  logic        cur_ue, cur_ut, cur_clr;
  logic        ev, et;
  logic [31:0] eg;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic logic [25:0] pc_tg(input logic [31:0] pc);
    return pc[31:6];
  endfunction

  function automatic logic [1:0] next_ctr(input logic [1:0] s, input logic taken);
    if (taken) return (s[1] || s == 2'b01) ? 2'b11 : 2'b01;
    return (s == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic taken,
                                       input logic [31:0] tgt);
    int i;
    i = pc_idx(pc);
    if (m_valid[i] && m_tag[i] == pc_tg(pc)) begin
      m_st[i] = next_ctr(m_st[i], taken);
      if (taken) m_tgt[i] = tgt;
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc_tg(pc);
      m_tgt[i]   = tgt;
      m_st[i]    = 2'b10;
    end
  endfunction

  function automatic void model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_st[i]    = 2'b00;
    end
  endfunction

  function automatic void model_expect();
    int i;
    bit          sv;
    logic [25:0] stag;
    logic [31:0] stgt;
    logic [1:0]  sst;
    i = pc_idx(cur_fpc);
    sv = m_valid[i]; stag = m_tag[i]; stgt = m_tgt[i]; sst = m_st[i];
`ifdef BTB_BYPASS_EN
    if (m_ready && !cur_clr && cur_ue && pc_idx(cur_upc) == i)
      model_update(cur_upc, cur_ut, cur_utg);
`endif
    ev = m_ready && m_valid[i] && (m_tag[i] == pc_tg(cur_fpc));
    et = ev && m_st[i][1];
    eg = ev ? m_tgt[i] : 32'h0;
    m_valid[i] = sv; m_tag[i] = stag; m_tgt[i] = stgt; m_st[i] = sst;
  endfunction

  function automatic void model_edge();
    if (!m_ready) begin
      if (cur_clr) m_cnt = 0;
      else if (m_cnt == N - 1) begin m_ready = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else if (cur_clr) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else if (cur_ue) begin
      model_update(cur_upc, cur_ut, cur_utg);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] fpc, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic clr);
    bif.fetch_pc   = fpc;  cur_fpc = fpc;
    bif.upd_en     = ue;   cur_ue  = ue;
    bif.upd_pc     = upc;  cur_upc = upc;
    bif.upd_taken  = ut;   cur_ut  = ut;
    bif.upd_target = utg;  cur_utg = utg;
    bif.clear      = clr;  cur_clr = clr;
    model_expect();
  endtask

  task automatic advance();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0;
    model_reset();
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bif.ready !== 1'b0 || dbg_state !== INIT) begin
      errors++;
      $display("FAIL reset_hold: ready=%b state=%0d expected ready=0 state=INIT",
               bif.ready, dbg_state);
    end
    nRST = 1'b1;
    for (int k = 0; k <= N; k++) begin
      if (k == 5) drive(32'h40, 1'b1, 32'h44, 1'b1, 32'h0000_0DEAD, 1'b0);
      else        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bif.ready !== (k == N)) begin
        errors++;
        $display("FAIL init_ready edge=%0d: got %b expected %b", k, bif.ready, (k == N));
      end
      checks++;
      if (bif.predict_valid !== 1'b0) begin
        errors++;
        $display("FAIL init_miss edge=%0d: got predict_valid=%b expected 0", k, bif.predict_valid);
      end
      if (k < N) advance();
    end
  endtask

  task automatic test_update_states();
    logic        ut_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] utg_tab [6] = '{32'hBAD0, 32'hBAD1, 32'hBAD2, 32'h104, 32'h108, 32'hBAD3};
    logic        exp_t   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_g   [6] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h108, 32'h108};
    drive(32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (bif.predict_valid !== 1'b0) begin
      errors++;
      $display("FAIL init_update_dropped: got predict_valid=%b expected 0", bif.predict_valid);
    end
    advance();
    drive(32'h40, 1'b1, 32'h44, 1'b1, 32'h100, 1'b0);
    advance();
    drive(32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_taken, bif.predict_target} !== {1'b1, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL allocate: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=00000100",
               bif.predict_valid, bif.predict_taken, bif.predict_target);
    end
    advance();
    for (int s = 0; s < 6; s++) begin
      drive(32'h0, 1'b1, 32'h44, ut_tab[s], utg_tab[s], 1'b0);
      advance();
      drive(32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bif.predict_valid, bif.predict_taken, bif.predict_target} !== {1'b1, exp_t[s], exp_g[s]}) begin
        errors++;
        $display("FAIL counter_step %0d: got v=%b t=%b tgt=%h expected v=1 t=%b tgt=%h",
                 s, bif.predict_valid, bif.predict_taken, bif.predict_target, exp_t[s], exp_g[s]);
      end
      advance();
    end
  endtask

  task automatic test_alias();
    drive(32'h0, 1'b1, 32'h84, 1'b1, 32'h300, 1'b0);
    advance();
    drive(32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_target} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL alias_old_miss: got v=%b tgt=%h expected v=0 tgt=00000000",
               bif.predict_valid, bif.predict_target);
    end
    advance();
    drive(32'h84, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_taken, bif.predict_target} !== {1'b1, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL alias_new_hit: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=00000300",
               bif.predict_valid, bif.predict_taken, bif.predict_target);
    end
    advance();
    drive(32'h0, 1'b1, 32'hC4, 1'b0, 32'h777, 1'b0);
    advance();
    drive(32'hC4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (bif.predict_valid !== 1'b0) begin
      errors++;
      $display("FAIL nt_miss_nowrite: got v=%b expected 0", bif.predict_valid);
    end
    advance();
    drive(32'h84, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_target} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL nt_miss_keeps: got v=%b tgt=%h expected v=1 tgt=00000300",
               bif.predict_valid, bif.predict_target);
    end
    advance();
  endtask

  task automatic test_same_cycle();
    logic        xv, xt;
    logic [31:0] xg;
`ifdef BTB_BYPASS_EN
    xv = 1'b1; xt = 1'b1; xg = 32'h500;
`else
    xv = 1'b0; xt = 1'b0; xg = 32'h0;
`endif
    drive(32'h58, 1'b1, 32'h58, 1'b1, 32'h500, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_taken, bif.predict_target} !== {xv, xt, xg}) begin
      errors++;
      $display("FAIL same_cycle: got v=%b t=%b tgt=%h expected v=%b t=%b tgt=%h",
               bif.predict_valid, bif.predict_taken, bif.predict_target, xv, xt, xg);
    end
    advance();
    drive(32'h58, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if ({bif.predict_valid, bif.predict_target} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL same_cycle_after: got v=%b tgt=%h expected v=1 tgt=00000500",
               bif.predict_valid, bif.predict_target);
    end
    advance();
    drive(32'h88, 1'b1, 32'h88, 1'b0, 32'h900, 1'b0);
    #1;
    checks++;
    if (bif.predict_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_nt_miss: got v=%b expected 0", bif.predict_valid);
    end
    advance();
  endtask

  task automatic test_clear();
    drive(32'h0, 1'b1, 32'h48, 1'b1, 32'h400, 1'b1);
    #1;
    checks++;
    if (bif.ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre_ready: got %b expected 1", bif.ready);
    end
    advance();
    for (int k = 0; k <= N; k++) begin
      drive(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bif.ready !== (k == N)) begin
        errors++;
        $display("FAIL clear_ready edge=%0d: got %b expected %b", k, bif.ready, (k == N));
      end
      if (k < N) advance();
    end
    advance();
    for (int p = 0; p < 4; p++) begin
      logic [31:0] pcs [4] = '{32'h48, 32'h44, 32'h84, 32'h58};
      drive(pcs[p], 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bif.predict_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_all_miss pc=%h: got v=%b expected 0", pcs[p], bif.predict_valid);
      end
      advance();
    end
  endtask

  task automatic test_clear_restart();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    advance();
    for (int k = 0; k < 7; k++) begin
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      advance();
    end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++;
    if (bif.ready !== 1'b0 || dbg_state !== INIT) begin
      errors++;
      $display("FAIL restart_mid_init: ready=%b state=%0d expected ready=0 state=INIT",
               bif.ready, dbg_state);
    end
    advance();
    for (int k = 0; k <= N; k++) begin
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bif.ready !== (k == N)) begin
        errors++;
        $display("FAIL restart_ready edge=%0d: got %b expected %b", k, bif.ready, (k == N));
      end
      if (k < N) advance();
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      logic [31:0] fpc, upc;
      fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      drive(fpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 99) == 0));
      #1;
      checks++;
      if ({bif.predict_valid, bif.predict_taken, bif.predict_target} !== {ev, et, eg}) begin
        errors++;
        $display("FAIL random_lookup cyc=%0d pc=%h: got v=%b t=%b tgt=%h expected v=%b t=%b tgt=%h",
                 c, fpc, bif.predict_valid, bif.predict_taken, bif.predict_target, ev, et, eg);
      end
      checks++;
      if (bif.ready !== m_ready || dbg_state !== (m_ready ? READY : INIT)) begin
        errors++;
        $display("FAIL random_ready cyc=%0d: got ready=%b state=%0d expected ready=%b",
                 c, bif.ready, dbg_state, m_ready);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h50, 1'b1, 32'h50, 1'b1, 32'h600, 1'b0);
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if (bif.ready !== 1'b0 || bif.predict_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b v=%b expected ready=0 v=0",
               bif.ready, bif.predict_valid);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
    for (int k = 0; k <= N; k++) begin
      drive(32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bif.ready !== (k == N)) begin
        errors++;
        $display("FAIL reset_mid_ready edge=%0d: got %b expected %b", k, bif.ready, (k == N));
      end
      if (k < N) advance();
    end
    checks++;
    if (bif.predict_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard: got v=%b expected 0", bif.predict_valid);
    end
    advance();
  endtask

  initial begin
    bif.fetch_pc = '0; bif.upd_en = 1'b0; bif.upd_pc = '0;
    bif.upd_taken = 1'b0; bif.upd_target = '0; bif.clear = 1'b0;
    test_reset();
    test_update_states();
    test_alias();
    test_same_cycle();
    test_clear();
    test_clear_restart();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
